// File: rtl/revuelve_cartas.sv
// Purpose: fills the card board with pairs and shuffles it (Fisher-Yates driven by a free-running LFSR).
// Latency: accepted start edge at cycle t -> ocupado from t+1, cartas_revueltas from t+2*N_CARTAS.
// Backpressure: none; start edges during a fill/shuffle are ignored, the board is read combinationally.
module revuelve_cartas #(
    parameter int          N_CARTAS = 16,
    parameter int          ADDR_W   = 4,
    parameter int          ID_W     = 3,
    parameter logic [15:0] SEMILLA  = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iniciar,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ID_W-1:0]   rd_data,
    output logic              ocupado,
    output logic              cartas_revueltas
);

    // An all-zero Galois LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0]       SEMILLA_EF = (SEMILLA == 16'h0000) ? 16'h0001 : SEMILLA;
    localparam logic [15:0]       MASCARA_LFSR = 16'hB400;
    localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(N_CARTAS - 1);

    typedef enum logic [1:0] {IDLE, LLENA, BARAJA, LISTO} estado_t;

    estado_t           estado;
    estado_t           estado_sig;
    logic [15:0]       lfsr;
    logic              iniciar_q;
    logic              inicio_ev;
    // idx is the fill position i during LLENA and the shuffle position k during BARAJA.
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] mascara;
    logic [ADDR_W-1:0] r;
    logic [ADDR_W-1:0] j;
    logic [ID_W-1:0]   tablero [N_CARTAS];

    assign inicio_ev = iniciar & ~iniciar_q;
    assign rd_data   = tablero[rd_addr];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next-state logic: fill for N_CARTAS cycles, shuffle for N_CARTAS-1 cycles, then hold.
    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE:    if (inicio_ev) estado_sig = LLENA;
            LLENA:   if (idx == ULTIMO) estado_sig = BARAJA;
            BARAJA:  if (idx == ADDR_W'(1)) estado_sig = LISTO;
            LISTO:   if (inicio_ev) estado_sig = LLENA;
            default: estado_sig = IDLE;
        endcase
    end

    // Output decode: busy while building the board, ready only while holding a finished one.
    always_comb begin
        ocupado          = 1'b0;
        cartas_revueltas = 1'b0;
        case (estado)
            LLENA, BARAJA: ocupado = 1'b1;
            LISTO:         cartas_revueltas = 1'b1;
            default:       ;
        endcase
    end

    // LFSR runs every cycle so the board depends on when the start arrives; start level is delayed for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr      <= SEMILLA_EF;
            iniciar_q <= 1'b0;
        end else begin
            lfsr      <= (lfsr >> 1) ^ (lfsr[0] ? MASCARA_LFSR : 16'h0000);
            iniciar_q <= iniciar;
        end
    end

    // Swap partner: mask the LFSR down to the smallest all-ones value covering k, then fold out-of-range draws back into 0..k.
    always_comb begin
        mascara = idx;
        for (int s = 1; s < ADDR_W; s++) begin
            mascara = mascara | (idx >> s);
        end
        r = lfsr[ADDR_W-1:0] & mascara;
        j = (r <= idx) ? r : (r - (idx + ADDR_W'(1)));
    end

    // Position counter: counts up while filling, down while shuffling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else begin
            case (estado)
                IDLE, LISTO: if (inicio_ev) idx <= '0;
                LLENA:       idx <= (idx == ULTIMO) ? ULTIMO : idx + ADDR_W'(1);
                BARAJA:      idx <= idx - ADDR_W'(1);
                default:     idx <= '0;
            endcase
        end
    end

    // Board storage: sequential pair fill, then one two-entry swap per cycle (j == k rewrites the same value).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int a = 0; a < N_CARTAS; a++) begin
                tablero[a] <= '0;
            end
        end else begin
            case (estado)
                LLENA: tablero[idx] <= ID_W'(idx >> 1);
                BARAJA: begin
                    tablero[idx] <= tablero[j];
                    tablero[j]   <= tablero[idx];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_revuelve_cartas.sv
module tb_revuelve_cartas;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst;
    logic       iniciar;
    logic [3:0] rd_addr;
    logic [2:0] rd_data;
    logic       ocupado;
    logic       cartas_revueltas;

    int checks = 0;
    int passed = 0;
    int cyc;

    logic [15:0][2:0] mb;
    logic [2:0]       got [16];

    typedef struct {
        logic [3:0] addr;
        logic [2:0] exp_data;
        logic       exp_ocup;
        logic       exp_rev;
    } rvec_t;

    typedef struct {
        int               dly;
        logic [15:0][2:0] board;
    } dvec_t;

    rvec_t rv [16];
    dvec_t dv [3];

    revuelve_cartas dut (
        .clk              (clk),
        .rst              (rst),
        .iniciar          (iniciar),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .ocupado          (ocupado),
        .cartas_revueltas (cartas_revueltas)
    );

    initial forever #5 clk = ~clk;

    // Edges seen since the last reset release.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] adv(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference shuffle: board for a start accepted on edge number ne after reset release.
    task automatic model(input int ne);
        logic [15:0] lf;
        int b [16];
        int m, r, j, t;
        lf = SEED;
        repeat (ne + 16) lf = adv(lf);
        for (int i = 0; i < 16; i++) b[i] = i / 2;
        for (int k = 15; k >= 1; k--) begin
            m = 1;
            while (m < k) m = m * 2 + 1;
            r = int'(lf[3:0]) & m;
            j = (r <= k) ? r : r - (k + 1);
            t = b[k]; b[k] = b[j]; b[j] = t;
            lf = adv(lf);
        end
        for (int i = 0; i < 16; i++) mb[i] = 3'(b[i]);
    endtask

    task automatic read_board();
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            got[a] = rd_data;
        end
    endtask

    task automatic check_board(input string name);
        int cnt [8];
        read_board();
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        for (int a = 0; a < 16; a++) begin
            chk(name, int'(got[a]), int'(mb[a]));
            cnt[got[a]]++;
        end
        for (int i = 0; i < 8; i++) chk({name, "_pairs"}, cnt[i], 2);
    endtask

    task automatic do_reset();
        iniciar = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Raise iniciar and follow the run cycle by cycle; optionally toggle it low/high mid-shuffle.
    task automatic run(input int toggle_c, output int ne);
        ne = 0;
        iniciar = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            step();
            if (c == 1) ne = cyc;
            chk("busy", int'({ocupado, cartas_revueltas}), 2);
            if (toggle_c != 0 && c == toggle_c)     iniciar = 1'b0;
            if (toggle_c != 0 && c == toggle_c + 1) iniciar = 1'b1;
        end
        step();
        chk("ready", int'({ocupado, cartas_revueltas}), 1);
        model(ne);
        check_board("board");
    endtask

    initial begin
        int ne;
        int bad;
        int diff;

        rd_addr = 4'd0;
        for (int a = 0; a < 16; a++) rv[a] = '{addr: 4'(a), exp_data: 3'd0, exp_ocup: 1'b0, exp_rev: 1'b0};
        dv[0].dly = 5;
        dv[1].dly = 5;
        dv[2].dly = 6;
        for (int i = 0; i < 3; i++) begin
            model(dv[i].dly + 1);
            dv[i].board = mb;
        end

        // Reset state across every read address.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            rd_addr = rv[i].addr;
            #1;
            chk("rst_data", int'(rd_data), int'(rv[i].exp_data));
            chk("rst_ocup", int'(ocupado), int'(rv[i].exp_ocup));
            chk("rst_rev", int'(cartas_revueltas), int'(rv[i].exp_rev));
        end

        // Determinism: start a fixed number of cycles after release.
        for (int i = 0; i < 3; i++) begin
            do_reset();
            repeat (dv[i].dly) step();
            run(0, ne);
            chk("det_start_edge", ne, dv[i].dly + 1);
            for (int a = 0; a < 16; a++) chk("det_board", int'(got[a]), int'(dv[i].board[a]));
            if (i == 2) begin
                diff = 0;
                for (int a = 0; a < 16; a++) if (got[a] != dv[0].board[a]) diff = 1;
                chk("det_differs", diff, 1);
            end
        end

        // Held start: no re-run while iniciar stays high.
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (cartas_revueltas !== 1'b1 || ocupado !== 1'b0) bad++;
        end
        chk("held_ready", bad, 0);
        check_board("held_board");

        // Restart after a one-cycle low.
        iniciar = 1'b0;
        step();
        run(0, ne);

        // Mid-shuffle start edge is ignored.
        iniciar = 1'b0;
        step();
        run(20, ne);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (cartas_revueltas !== 1'b1) bad++;
        end
        chk("no_extra_run", bad, 0);

        // Reset in the middle of a shuffle.
        iniciar = 1'b0;
        step();
        iniciar = 1'b1;
        repeat (20) step();
        rst = 1'b0;
        #1;
        chk("midrst_ocup", int'(ocupado), 0);
        chk("midrst_rev", int'(cartas_revueltas), 0);
        read_board();
        bad = 0;
        for (int a = 0; a < 16; a++) if (got[a] != 3'd0) bad++;
        chk("midrst_board", bad, 0);
        do_reset();
        step();
        run(0, ne);

        // Randomized start times and restart patterns against the reference model.
        for (int n = 0; n < 6; n++) begin
            do_reset();
            repeat ($urandom_range(0, 40)) step();
            run(0, ne);
            for (int s = 0; s < 2; s++) begin
                repeat ($urandom_range(1, 10)) step();
                iniciar = 1'b0;
                repeat ($urandom_range(1, 3)) step();
                run(0, ne);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
